// File: rtl/note_highway.sv
// Falling-note renderer: scans the frame one pixel per clk, scrolls a ROWS-deep note shift register fed from the chart ROM.
// Optional macro NOTE_HIGHWAY_HITGLOW_EN adds key_down[] so pressed lanes light up their hit line.
module note_highway #(
    parameter int LANES    = 4,
    parameter int ROWS     = 12,
    parameter int ROW_H    = 20,
    parameter int SCR_W    = 320,
    parameter int SCR_H    = 240,
    parameter int LANE_X0  = 125,
    parameter int LANE_W   = 16,
    parameter int LANE_GAP = 2,
    parameter int HIT_Y    = 220,
    parameter int TICK_DIV = 833333,
    parameter int ADDR_W   = 13,
    parameter int SONG_LEN = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pause,
`ifdef NOTE_HIGHWAY_HITGLOW_EN
    input  logic [LANES-1:0]  key_down,
`endif
    output logic              note_req,
    output logic [ADDR_W-1:0] note_addr,
    input  logic              note_valid,
    input  logic [LANES-1:0]  note_data,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic [2:0]        colour,
    output logic [LANES-1:0]  hit_lanes,
    output logic              row_shift,
    output logic              song_done
);

    localparam int PITCH = LANE_W + LANE_GAP;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OFF_W = (ROW_H > 1) ? $clog2(ROW_H) : 1;

    typedef enum logic {SCROLL, FETCH} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [LANES-1:0]    rows_q [ROWS];
    logic [LANES-1:0]    rows_d [ROWS];
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                done_q, done_d;
    logic                row_shift_q, row_shift_d;
    logic [8:0]          x_q, x_d;
    logic [7:0]          y_q, y_d;
    logic [7:0]          yrow_q, yrow_d;
    logic [OFF_W-1:0]    ysub_q, ysub_d;
    logic [2:0]          colour_q, colour_d;
    logic                shift_en;
    logic [LANES-1:0]    shift_data;

    function automatic logic [2:0] lane_colour(input int k);
        case (k % 4)
            0:       return 3'b101;
            1:       return 3'b110;
            2:       return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    // yrow/ysub track y/ROW_H and y%ROW_H so the row lookup needs no divider.
    always_comb begin
        x_d    = x_q + 9'd1;
        y_d    = y_q;
        yrow_d = yrow_q;
        ysub_d = ysub_q;
        if (x_q == 9'(SCR_W - 1)) begin
            x_d = '0;
            if (y_q == 8'(SCR_H - 1)) begin
                y_d    = '0;
                yrow_d = '0;
                ysub_d = '0;
            end else begin
                y_d = y_q + 8'd1;
                if (ysub_q == OFF_W'(ROW_H - 1)) begin
                    ysub_d = '0;
                    yrow_d = yrow_q + 8'd1;
                end else begin
                    ysub_d = ysub_q + 1'b1;
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        offset_d   = offset_q;
        addr_d     = addr_q;
        done_d     = done_q;
        shift_en   = 1'b0;
        shift_data = '0;
        case (state_q)
            SCROLL: begin
                if (!pause) begin
                    if (div_q == DIV_W'(TICK_DIV - 1)) begin
                        div_d = '0;
                        if (offset_q == OFF_W'(ROW_H - 1)) begin
                            offset_d = '0;
                            state_d  = FETCH;
                        end else begin
                            offset_d = offset_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                if (done_q) begin
                    shift_en = 1'b1;
                    state_d  = SCROLL;
                end else if (note_valid) begin
                    shift_en   = 1'b1;
                    shift_data = note_data;
                    addr_d     = addr_q + 1'b1;
                    done_d     = (addr_d == ADDR_W'(SONG_LEN));
                    state_d    = SCROLL;
                end
            end
            default: state_d = SCROLL;
        endcase
        row_shift_d = shift_en;
        rows_d      = rows_q;
        if (shift_en) begin
            for (int r = ROWS - 1; r > 0; r--) rows_d[r] = rows_q[r-1];
            rows_d[0] = shift_data;
        end
    end

    // Colour for the pixel the scan moves to next, so it registers alongside x/y.
    always_comb begin
        logic             in_lane, border, row_ok;
        logic [LANES-1:0] lane_mask, row_bits;
        logic [2:0]       lane_col, hit_col;
        logic [7:0]       row_idx;
        in_lane   = 1'b0;
        border    = 1'b0;
        lane_mask = '0;
        lane_col  = 3'b111;
        row_ok    = 1'b0;
        row_idx   = '0;
        row_bits  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(x_d) >= LANE_X0 + k * PITCH && int'(x_d) < LANE_X0 + k * PITCH + LANE_W) begin
                in_lane      = 1'b1;
                lane_mask[k] = 1'b1;
                lane_col     = lane_colour(k);
            end
        end
        for (int k = 0; k <= LANES; k++) begin
            if (int'(x_d) >= LANE_X0 + k * PITCH - LANE_GAP && int'(x_d) < LANE_X0 + k * PITCH)
                border = 1'b1;
        end
        if (ysub_d >= offset_q) begin
            row_ok  = 1'b1;
            row_idx = yrow_d;
        end else if (yrow_d != 8'd0) begin
            row_ok  = 1'b1;
            row_idx = yrow_d - 8'd1;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_ok && row_idx == 8'(r)) row_bits = rows_q[r];
        end
`ifdef NOTE_HIGHWAY_HITGLOW_EN
        hit_col = (|(key_down & lane_mask)) ? lane_col : 3'b000;
`else
        hit_col = 3'b000;
`endif
        if (in_lane && (y_d == 8'(HIT_Y) || y_d == 8'(HIT_Y + 1)))
            colour_d = hit_col;
        else if (in_lane && |(row_bits & lane_mask))
            colour_d = lane_col;
        else if (border)
            colour_d = 3'b000;
        else
            colour_d = 3'b111;
    end

    // NOTE: state registers use non-blocking assignments only; the note rows are reset too, since a reset must clear the screen.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= SCROLL;
            div_q       <= '0;
            offset_q    <= '0;
            rows_q      <= '{default: '0};
            addr_q      <= '0;
            done_q      <= 1'b0;
            row_shift_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            yrow_q      <= '0;
            ysub_q      <= '0;
            colour_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            offset_q    <= offset_d;
            rows_q      <= rows_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            row_shift_q <= row_shift_d;
            x_q         <= x_d;
            y_q         <= y_d;
            yrow_q      <= yrow_d;
            ysub_q      <= ysub_d;
            colour_q    <= colour_d;
        end
    end

    assign note_req  = (state_q == FETCH) && !done_q;
    assign note_addr = addr_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign hit_lanes = rows_q[ROWS-1];
    assign row_shift = row_shift_q;
    assign song_done = done_q;

endmodule
